// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the word-level register-file master:
//   register index constants, register count, left/right side split,
//   command opcodes and the sequencing FSM states.
package regfile_pkg;

  localparam int NUM_REGS  = 14;
  // Indices 0..LEFT_LAST live on the left (pc) bus, the rest on the right bus.
  localparam int LEFT_LAST = 1;

  localparam logic [3:0] REG_PC  = 4'd0;
  localparam logic [3:0] REG_IR  = 4'd1;
  localparam logic [3:0] REG_WZ  = 4'd2;
  localparam logic [3:0] REG_SP  = 4'd3;
  localparam logic [3:0] REG_IY  = 4'd4;
  localparam logic [3:0] REG_IX  = 4'd5;
  localparam logic [3:0] REG_HL1 = 4'd6;
  localparam logic [3:0] REG_HL0 = 4'd7;
  localparam logic [3:0] REG_DE1 = 4'd8;
  localparam logic [3:0] REG_DE0 = 4'd9;
  localparam logic [3:0] REG_BC1 = 4'd10;
  localparam logic [3:0] REG_BC0 = 4'd11;
  localparam logic [3:0] REG_AF1 = 4'd12;
  localparam logic [3:0] REG_AF0 = 4'd13;

  typedef enum logic [1:0] {
    OP_RD = 2'd0,
    OP_WR = 2'd1,
    OP_CP = 2'd2,
    OP_EX = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_CAP_A,
    ST_RD_B,
    ST_CAP_B,
    ST_WR_A,
    ST_WR_B,
    ST_RESP
  } state_e;

endpackage

// File: rtl/regfile_sel_decode.sv
// regfile_sel_decode
//   Combinational register-index decoder.
//   idx_i     : 4-bit register index
//   onehot_o  : one-hot slice select (bit i = index i), all zero if illegal
//   is_left_o : index belongs to the left (pc) bus
//   illegal_o : index is outside 0..NUM_REGS-1
module regfile_sel_decode
  import regfile_pkg::*;
(
  input  logic [3:0]          idx_i,
  output logic [NUM_REGS-1:0] onehot_o,
  output logic                is_left_o,
  output logic                illegal_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
      assign onehot_o[gi] = (idx_i == 4'(gi));
    end
  endgenerate

  assign is_left_o = (idx_i <= 4'(LEFT_LAST));
  assign illegal_o = (idx_i >= 4'(NUM_REGS));

endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//   Word-level master for the bit-sliced register file. Accepts RD/WR/CP/EX
//   commands, sequences slice select, write strobes and data buses, samples
//   the registered slice outputs and returns a response.
//   eclk/erst          : clock, asynchronous active-high reset
//   cmd_*              : command channel (valid/ready), op, indices A/B, data
//   rsp_*              : response channel (valid/ready), data, illegal-index flag
//   sel                : one-hot slice select
//   pc_wr/pc_din       : left bus write strobe and data (indices 0..1)
//   reg_wr/reg_din     : right bus write strobe and data (indices 2..13)
//   pc_dout/reg_dout   : registered slice outputs (pc_dout is inverted)
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                eclk,
  input  logic                erst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [3:0]          cmd_a,
  input  logic [3:0]          cmd_b,
  input  logic [WIDTH-1:0]    cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_data,
  output logic                rsp_err,
  output logic [NUM_REGS-1:0] sel,
  output logic                pc_wr,
  output logic                reg_wr,
  output logic [WIDTH-1:0]    pc_din,
  output logic [WIDTH-1:0]    reg_din,
  input  logic [WIDTH-1:0]    pc_dout,
  input  logic [WIDTH-1:0]    reg_dout
);

  state_e            state_q, state_d;
  logic              ready_q;
  op_e               op_q;
  logic [3:0]        a_q, b_q;
  logic [WIDTH-1:0]  data_q;
  logic              err_q;
  logic [WIDTH-1:0]  hold_a_q, hold_b_q;

  logic              accept;
  logic [3:0]        idx_a, idx_b;
  logic [NUM_REGS-1:0] onehot_a, onehot_b;
  logic              left_a, left_b, ill_a, ill_b;
  logic              cmd_uses_b, cmd_err;
  logic [WIDTH-1:0]  rd_val_a, rd_val_b;

  // In IDLE the decoders look at the live command so legality can be judged
  // on the accept edge; afterwards they follow the latched indices.
  assign idx_a = (state_q == ST_IDLE) ? cmd_a : a_q;
  assign idx_b = (state_q == ST_IDLE) ? cmd_b : b_q;

  regfile_sel_decode u_dec_a (
    .idx_i     (idx_a),
    .onehot_o  (onehot_a),
    .is_left_o (left_a),
    .illegal_o (ill_a)
  );

  regfile_sel_decode u_dec_b (
    .idx_i     (idx_b),
    .onehot_o  (onehot_b),
    .is_left_o (left_b),
    .illegal_o (ill_b)
  );

  assign accept     = cmd_valid & ready_q;
  assign cmd_uses_b = (cmd_op == OP_CP) | (cmd_op == OP_EX);
  assign cmd_err    = ill_a | (cmd_uses_b & ill_b);

  // Left-side slices present their value inverted.
  assign rd_val_a = left_a ? ~pc_dout : reg_dout;
  assign rd_val_b = left_b ? ~pc_dout : reg_dout;

  assign cmd_ready = ready_q;

  always_comb begin
    state_d = state_q;
    sel     = '0;
    pc_wr   = 1'b0;
    reg_wr  = 1'b0;
    pc_din  = '0;
    reg_din = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Illegal commands take one bus-silent cycle in CAP_A (sel=0, no
          // strobes) so the error response shares the WR response latency.
          if (cmd_err)               state_d = ST_CAP_A;
          else if (cmd_op == OP_WR)  state_d = ST_WR_A;
          else                       state_d = ST_RD_A;
        end
      end
      ST_RD_A: begin
        sel     = onehot_a;
        state_d = ST_CAP_A;
      end
      ST_CAP_A: begin
        if (err_q || op_q == OP_RD) state_d = ST_RESP;
        else if (op_q == OP_CP)     state_d = ST_WR_B;
        else                        state_d = ST_RD_B;
      end
      ST_RD_B: begin
        sel     = onehot_b;
        state_d = ST_CAP_B;
      end
      ST_CAP_B: begin
        state_d = ST_WR_A;
      end
      ST_WR_A: begin
        sel = onehot_a;
        if (left_a) begin
          pc_wr  = 1'b1;
          pc_din = (op_q == OP_WR) ? data_q : hold_b_q;
        end else begin
          reg_wr  = 1'b1;
          reg_din = (op_q == OP_WR) ? data_q : hold_b_q;
        end
        state_d = (op_q == OP_WR) ? ST_RESP : ST_WR_B;
      end
      ST_WR_B: begin
        sel = onehot_b;
        if (left_b) begin
          pc_wr  = 1'b1;
          pc_din = hold_a_q;
        end else begin
          reg_wr  = 1'b1;
          reg_din = hold_a_q;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_data  = (rsp_valid && !err_q) ? ((op_q == OP_WR) ? data_q : hold_a_q)
                                           : '0;

  always_ff @(posedge eclk or posedge erst) begin
    if (erst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      op_q     <= OP_RD;
      a_q      <= '0;
      b_q      <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else begin
      state_q <= state_d;
      // Ready is high exactly when the FSM sits in IDLE, low through reset.
      ready_q <= (state_d == ST_IDLE);
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        a_q    <= cmd_a;
        b_q    <= cmd_b;
        data_q <= cmd_data;
        err_q  <= cmd_err;
      end
      if (state_q == ST_CAP_A && !err_q) hold_a_q <= rd_val_a;
      if (state_q == ST_CAP_B)           hold_b_q <= rd_val_b;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl
//   Directed bench: a simple behavioural slice array (registered outputs,
//   left bus inverted) sits behind the DUT; commands are issued and
//   responses, latencies and bus activity are compared against hand values.
module tb_regfile_access_ctrl;

  localparam int W = 16;

  logic          eclk = 1'b0;
  logic          erst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [3:0]    cmd_a = 4'd0;
  logic [3:0]    cmd_b = 4'd0;
  logic [W-1:0]  cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_data;
  logic          rsp_err;
  logic [13:0]   sel;
  logic          pc_wr, reg_wr;
  logic [W-1:0]  pc_din, reg_din;
  logic [W-1:0]  pc_dout, reg_dout;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_access_ctrl #(.WIDTH(W)) dut (
    .eclk(eclk), .erst(erst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .sel(sel), .pc_wr(pc_wr), .reg_wr(reg_wr),
    .pc_din(pc_din), .reg_din(reg_din), .pc_dout(pc_dout), .reg_dout(reg_dout)
  );

  always #5 eclk = ~eclk;

  // Behavioural slice array: not reset by erst (slices keep their contents).
  logic [W-1:0] regs [14];
  logic [W-1:0] left_v, right_v;
  initial for (int i = 0; i < 14; i++) regs[i] = '0;

  always_comb begin
    left_v  = '0;
    right_v = '0;
    for (int i = 0; i < 14; i++) begin
      if (sel[i] && i <= 1) left_v  = left_v | regs[i];
      if (sel[i] && i >= 2) right_v = right_v | regs[i];
    end
  end

  always @(posedge eclk) begin
    for (int i = 0; i < 14; i++) begin
      if (sel[i] && i <= 1 && pc_wr)  regs[i] <= pc_din;
      if (sel[i] && i >= 2 && reg_wr) regs[i] <= reg_din;
    end
    pc_dout  <= ~left_v;
    reg_dout <= right_v;
  end

  // Bus activity monitor, sampled mid-cycle.
  int          strobe_cycles = 0;
  int          sel_cycles    = 0;
  logic [13:0] last_wr_sel   = '0;
  logic        last_was_pc   = 1'b0;
  always @(negedge eclk) begin
    if (sel != '0) sel_cycles++;
    if (pc_wr || reg_wr) begin
      strobe_cycles++;
      last_wr_sel = sel;
      last_was_pc = pc_wr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and collect its response; lat counts edges after accept.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [W-1:0] d, output logic [W-1:0] rdata,
                        output logic rerr, output int lat);
    int waited = 0;
    @(negedge eclk);
    while (!cmd_ready && waited < 50) begin
      @(negedge eclk);
      waited++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    strobe_cycles = 0;
    sel_cycles    = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_data = d;
    @(posedge eclk);
    #1;
    cmd_valid = 1'b0; cmd_data = '0; cmd_a = 4'd0; cmd_b = 4'd0;
    lat = 0;
    @(negedge eclk);
    while (!rsp_valid && lat < 20) begin
      @(posedge eclk);
      lat++;
      @(negedge eclk);
    end
    rdata = rsp_data;
    rerr  = rsp_err;
    rsp_ready = 1'b1;
    @(posedge eclk);
    #1;
    rsp_ready = 1'b0;
    $display("txn op=%0d a=%0d b=%0d din=0x%04h -> data=0x%04h err=%0d lat=%0d",
             op, a, b, d, rdata, rerr, lat);
  endtask

  logic [W-1:0] rd;
  logic         re;
  int           lt;

  initial begin
    // Reset state
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_outputs", {pc_wr, reg_wr, 16'(sel)}, 32'd0);
    check("rst_din", {pc_din, reg_din}, 32'd0);
    @(negedge eclk);
    erst = 1'b0;
    @(negedge eclk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // WR sp, RD sp
    do_cmd(2'd1, 4'd3, 4'd0, 16'h1234, rd, re, lt);
    check("wr_sp_lat", lt, 1);
    check("wr_sp_rsp", rd, 16'h1234);
    check("wr_sp_strobes", strobe_cycles, 1);
    check("wr_sp_sel", 32'(last_wr_sel), 32'h0008);
    check("wr_sp_side", 32'(last_was_pc), 32'd0);
    do_cmd(2'd0, 4'd3, 4'd0, 16'h0, rd, re, lt);
    check("rd_sp_lat", lt, 2);
    check("rd_sp_data", rd, 16'h1234);
    check("rd_sp_err", 32'(re), 32'd0);

    // WR pc, RD pc through the inverted left bus
    do_cmd(2'd1, 4'd0, 4'd0, 16'hBEEF, rd, re, lt);
    check("wr_pc_sel", 32'(last_wr_sel), 32'h0001);
    check("wr_pc_side", 32'(last_was_pc), 32'd1);
    do_cmd(2'd0, 4'd0, 4'd0, 16'h0, rd, re, lt);
    check("rd_pc_data", rd, 16'hBEEF);

    // EX hl0 <-> de0
    do_cmd(2'd1, 4'd7, 4'd0, 16'h00FF, rd, re, lt);
    do_cmd(2'd1, 4'd9, 4'd0, 16'hAA55, rd, re, lt);
    do_cmd(2'd3, 4'd7, 4'd9, 16'h0, rd, re, lt);
    check("ex_lat", lt, 6);
    check("ex_rsp", rd, 16'h00FF);
    check("ex_strobes", strobe_cycles, 2);
    do_cmd(2'd0, 4'd7, 4'd0, 16'h0, rd, re, lt);
    check("ex_hl0", rd, 16'hAA55);
    do_cmd(2'd0, 4'd9, 4'd0, 16'h0, rd, re, lt);
    check("ex_de0", rd, 16'h00FF);

    // CP pc -> ix
    do_cmd(2'd1, 4'd0, 4'd0, 16'h8001, rd, re, lt);
    do_cmd(2'd2, 4'd0, 4'd5, 16'h0, rd, re, lt);
    check("cp_lat", lt, 3);
    check("cp_rsp", rd, 16'h8001);
    do_cmd(2'd0, 4'd5, 4'd0, 16'h0, rd, re, lt);
    check("cp_ix", rd, 16'h8001);
    do_cmd(2'd0, 4'd0, 4'd0, 16'h0, rd, re, lt);
    check("cp_pc_kept", rd, 16'h8001);

    // EX with A==B rewrites the same value
    do_cmd(2'd3, 4'd3, 4'd3, 16'h0, rd, re, lt);
    check("ex_same_rsp", rd, 16'h1234);
    do_cmd(2'd0, 4'd3, 4'd0, 16'h0, rd, re, lt);
    check("ex_same_sp", rd, 16'h1234);

    // Illegal index on A
    do_cmd(2'd0, 4'd15, 4'd0, 16'h0, rd, re, lt);
    check("ill_a_lat", lt, 1);
    check("ill_a_err", 32'(re), 32'd1);
    check("ill_a_data", rd, 16'h0);
    check("ill_a_sel_cycles", sel_cycles, 0);
    check("ill_a_strobes", strobe_cycles, 0);

    // Illegal index on B of a CP leaves the target untouched
    do_cmd(2'd2, 4'd3, 4'd14, 16'h0, rd, re, lt);
    check("ill_b_err", 32'(re), 32'd1);
    check("ill_b_strobes", strobe_cycles, 0);
    // Illegal B is ignored by WR
    do_cmd(2'd1, 4'd4, 4'd15, 16'h2222, rd, re, lt);
    check("wr_ignores_b", 32'(re), 32'd0);

    // Reset during the write phase of EX ix <-> iy (ix=0x8001, iy=0x2222)
    @(negedge eclk);
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_a = 4'd5; cmd_b = 4'd4;
    @(posedge eclk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(posedge eclk);   // edge 5 ends WR_A: A now holds old B
    #1;
    check("ex_in_wr_b", 32'(reg_wr), 32'd1);
    erst = 1'b1;
    #1;
    check("rst_strobe_drop", {pc_wr, reg_wr, 16'(sel)}, 32'd0);
    check("rst_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge eclk);
    @(negedge eclk);
    erst = 1'b0;
    @(negedge eclk);
    check("rst_ready_back", 32'(cmd_ready), 32'd1);
    check("rst_rsp_idle", 32'(rsp_valid), 32'd0);
    do_cmd(2'd0, 4'd5, 4'd0, 16'h0, rd, re, lt);
    check("rst_a_new", rd, 16'h2222);
    do_cmd(2'd0, 4'd4, 4'd0, 16'h0, rd, re, lt);
    check("rst_b_kept", rd, 16'h2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
